// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM.
// Supports fixed-priority or round-robin grant, and a read latency set by RD_LAT.
module sram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_fixed_prio,
    input  logic        a_req,
    input  logic        a_we_n,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we_n,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        csb_n,
    output logic        we_n,
    output logic [4:0]  addr,
    output logic [31:0] sram_data_in,
    input  logic [31:0] sram_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        last_b;
    logic        grant_a;
    logic        pick_a;
    logic        any_req;
    logic        lat_we_n;
    logic [4:0]  lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  cnt;

    assign any_req = a_req || b_req;
    // On contention, A wins under fixed priority or when B was granted last.
    assign pick_a  = (a_req && b_req) ? (cfg_fixed_prio || last_b) : a_req;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = lat_we_n ? WAIT : IDLE;
            WAIT:    if (cnt == 2'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b    <= 1'b1;
            grant_a   <= 1'b0;
            lat_we_n  <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_a   <= pick_a;
                last_b    <= !pick_a;
                lat_we_n  <= pick_a ? a_we_n  : b_we_n;
                lat_addr  <= pick_a ? a_addr  : b_addr;
                lat_wdata <= pick_a ? a_wdata : b_wdata;
            end
            if (state == ACCESS) cnt <= CNT_INIT;
            if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    if (grant_a) a_rdata <= sram_data_out;
                    else         b_rdata <= sram_data_out;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end

    always_comb begin
        csb_n        = 1'b1;
        we_n         = 1'b1;
        addr         = '0;
        sram_data_in = '0;
        a_ack        = 1'b0;
        b_ack        = 1'b0;
        busy         = (state != IDLE);
        case (state)
            ACCESS: begin
                csb_n        = 1'b0;
                we_n         = lat_we_n;
                addr         = lat_addr;
                sram_data_in = lat_we_n ? 32'd0 : lat_wdata;
                a_ack        = grant_a && !lat_we_n;
                b_ack        = !grant_a && !lat_we_n;
            end
            RESP: begin
                a_ack = grant_a;
                b_ack = !grant_a;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3
// share stimulus, each backed by its own behavioural SRAM.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst, cfg_fixed_prio;
    logic        a_req, a_we_n, b_req, b_we_n;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        a_ack1, b_ack1, csb_n1, we_n1, busy1;
    logic [31:0] a_rdata1, b_rdata1, sram_data_in1;
    logic [4:0]  addr1;
    logic [31:0] q1 = '0;
    logic [31:0] mem1 [32];

    logic        a_ack3, b_ack3, csb_n3, we_n3, busy3;
    logic [31:0] a_rdata3, b_rdata3, sram_data_in3;
    logic [4:0]  addr3;
    logic [31:0] q3 = '0;
    logic [31:0] mem3 [32];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_fixed_prio(cfg_fixed_prio),
        .a_req(a_req), .a_we_n(a_we_n), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we_n(b_we_n), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack1), .b_rdata(b_rdata1),
        .csb_n(csb_n1), .we_n(we_n1), .addr(addr1), .sram_data_in(sram_data_in1),
        .sram_data_out(q1), .busy(busy1)
    );

    sram_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_fixed_prio(cfg_fixed_prio),
        .a_req(a_req), .a_we_n(a_we_n), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack3), .a_rdata(a_rdata3),
        .b_req(b_req), .b_we_n(b_we_n), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack3), .b_rdata(b_rdata3),
        .csb_n(csb_n3), .we_n(we_n3), .addr(addr3), .sram_data_in(sram_data_in3),
        .sram_data_out(q3), .busy(busy3)
    );

    // Synchronous SRAMs: read data appears after the access edge and holds.
    always @(posedge clk) begin
        if (!csb_n1) begin
            if (!we_n1) mem1[addr1] <= sram_data_in1;
            else        q1 <= mem1[addr1];
        end
        if (!csb_n3) begin
            if (!we_n3) mem3[addr3] <= sram_data_in3;
            else        q3 <= mem3[addr3];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_fixed_prio = 1'b0;
        a_req = 1'b0; a_we_n = 1'b1; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we_n = 1'b1; b_addr = '0; b_wdata = '0;
        step();
        step();
        total++;
        if ({csb_n1, we_n1, addr1, sram_data_in1} !== {1'b1, 1'b1, 5'd0, 32'd0})
            $display("FAIL reset_bus1: got %b/%b/%h/%h exp 1/1/00/00000000", csb_n1, we_n1, addr1, sram_data_in1);
        else passed++;
        total++;
        if ({a_ack1, b_ack1, busy1, a_ack3, b_ack3, busy3} !== 6'b0)
            $display("FAIL reset_ack_busy: got %b exp 000000", {a_ack1, b_ack1, busy1, a_ack3, b_ack3, busy3});
        else passed++;
        total++;
        if ({a_rdata1, b_rdata1, a_rdata3, b_rdata3} !== 128'd0)
            $display("FAIL reset_rdata: got %h %h %h %h exp all 0", a_rdata1, b_rdata1, a_rdata3, b_rdata3);
        else passed++;
        total++;
        if ({csb_n3, we_n3, addr3, sram_data_in3} !== {1'b1, 1'b1, 5'd0, 32'd0})
            $display("FAIL reset_bus3: got %b/%b/%h/%h exp 1/1/00/00000000", csb_n3, we_n3, addr3, sram_data_in3);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_write();
        a_req = 1'b1; a_we_n = 1'b0; a_addr = 5'h03; a_wdata = 32'hDEADBEEF;
        step();
        total++;
        if ({csb_n1, we_n1, addr1, sram_data_in1} !== {1'b0, 1'b0, 5'h03, 32'hDEADBEEF})
            $display("FAIL wr_bus: got %b/%b/%h/%h exp 0/0/03/deadbeef", csb_n1, we_n1, addr1, sram_data_in1);
        else passed++;
        total++;
        if ({a_ack1, b_ack1, busy1, a_ack3, b_ack3} !== 5'b10110)
            $display("FAIL wr_ack: got %b exp 10110", {a_ack1, b_ack1, busy1, a_ack3, b_ack3});
        else passed++;
        a_req = 1'b0;
        step();
        total++;
        if ({busy1, csb_n1, a_ack1} !== 3'b010)
            $display("FAIL wr_idle: got %b exp 010", {busy1, csb_n1, a_ack1});
        else passed++;
    endtask

    task automatic test_read();
        b_req = 1'b1; b_we_n = 1'b1; b_addr = 5'h03; b_wdata = 32'h55555555;
        step();
        total++;
        if ({csb_n1, we_n1, addr1, sram_data_in1, a_ack1, b_ack1, busy1} !== {1'b0, 1'b1, 5'h03, 32'd0, 3'b001})
            $display("FAIL rd_access: got %b/%b/%h/%h/%b exp 0/1/03/00000000/001", csb_n1, we_n1, addr1, sram_data_in1, {a_ack1, b_ack1, busy1});
        else passed++;
        step();
        total++;
        if ({csb_n1, we_n1, addr1, a_ack1, b_ack1, busy1} !== {1'b1, 1'b1, 5'd0, 3'b001})
            $display("FAIL rd_wait: got %b/%b/%h/%b exp 1/1/00/001", csb_n1, we_n1, addr1, {a_ack1, b_ack1, busy1});
        else passed++;
        step();
        total++;
        if ({a_ack1, b_ack1, busy1} !== 3'b011)
            $display("FAIL rd_resp_ack: got %b exp 011", {a_ack1, b_ack1, busy1});
        else passed++;
        total++;
        if ({b_rdata1, a_rdata1} !== {32'hDEADBEEF, 32'd0})
            $display("FAIL rd_rdata: got b=%h a=%h exp b=deadbeef a=00000000", b_rdata1, a_rdata1);
        else passed++;
        b_req = 1'b0;
        step();
        total++;
        if ({a_ack1, b_ack1, busy1, b_rdata1, a_ack3, b_ack3, busy3} !== {3'b000, 32'hDEADBEEF, 3'b001})
            $display("FAIL rd_after: got %b %h %b exp 000 deadbeef 001", {a_ack1, b_ack1, busy1}, b_rdata1, {a_ack3, b_ack3, busy3});
        else passed++;
        step();
        total++;
        if ({a_ack3, b_ack3, busy3, b_rdata3, a_rdata3} !== {3'b011, 32'hDEADBEEF, 32'd0})
            $display("FAIL rd3_resp: got %b b=%h a=%h exp 011 deadbeef 00000000", {a_ack3, b_ack3, busy3}, b_rdata3, a_rdata3);
        else passed++;
        step();
        total++;
        if ({a_ack3, b_ack3, busy3} !== 3'b000)
            $display("FAIL rd3_idle: got %b exp 000", {a_ack3, b_ack3, busy3});
        else passed++;
    endtask

    task automatic test_round_robin();
        logic exp_a;
        apply_reset();
        cfg_fixed_prio = 1'b0;
        a_req = 1'b1; a_we_n = 1'b0; a_addr = 5'd1; a_wdata = 32'hAAAA0001;
        b_req = 1'b1; b_we_n = 1'b0; b_addr = 5'd2; b_wdata = 32'hBBBB0002;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            step();
            total++;
            if ({a_ack1, b_ack1, busy1, addr1} !== {exp_a, !exp_a, 1'b1, (exp_a ? 5'd1 : 5'd2)})
                $display("FAIL rr_grant%0d: got %b addr %h exp %b%b1 addr %0d", i, {a_ack1, b_ack1, busy1}, addr1, exp_a, !exp_a, exp_a ? 1 : 2);
            else passed++;
            step();
            total++;
            if ({busy1, a_ack1, b_ack1} !== 3'b000)
                $display("FAIL rr_idle%0d: got %b exp 000", i, {busy1, a_ack1, b_ack1});
            else passed++;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        cfg_fixed_prio = 1'b1;
        a_req = 1'b1; a_we_n = 1'b0; a_addr = 5'd4; a_wdata = 32'h0000A0A0;
        b_req = 1'b1; b_we_n = 1'b0; b_addr = 5'd5; b_wdata = 32'h0000B0B0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({a_ack1, b_ack1, busy1} !== 3'b101)
                $display("FAIL fp_grant%0d: got %b exp 101", i, {a_ack1, b_ack1, busy1});
            else passed++;
            if (i == 2) a_req = 1'b0;
            step();
        end
        step();
        total++;
        if ({a_ack1, b_ack1, busy1, addr1, sram_data_in1} !== {3'b011, 5'd5, 32'h0000B0B0})
            $display("FAIL fp_b_after_release: got %b addr %h data %h exp 011 addr 05 data 0000b0b0", {a_ack1, b_ack1, busy1}, addr1, sram_data_in1);
        else passed++;
        b_req = 1'b0; cfg_fixed_prio = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        apply_reset();
        a_req = 1'b1; a_we_n = 1'b1; a_addr = 5'h03;
        step();
        step();
        step();
        total++;
        if ({busy3, csb_n3, a_ack3} !== 3'b110)
            $display("FAIL abort_in_wait: got %b exp 110", {busy3, csb_n3, a_ack3});
        else passed++;
        a_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({csb_n3, a_ack3, b_ack3, busy3, a_rdata3} !== {4'b1000, 32'd0})
            $display("FAIL abort_reset: got %b rdata %h exp 1000 rdata 00000000", {csb_n3, a_ack3, b_ack3, busy3}, a_rdata3);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({a_ack3, busy3, csb_n3, a_rdata3} !== {3'b001, 32'd0})
                $display("FAIL abort_quiet%0d: got %b rdata %h exp 001 rdata 00000000", i, {a_ack3, busy3, csb_n3}, a_rdata3);
            else passed++;
        end
        a_req = 1'b1; a_we_n = 1'b0; a_addr = 5'd7; a_wdata = 32'h12345678;
        step();
        total++;
        if ({csb_n3, we_n3, addr3, sram_data_in3, a_ack3} !== {1'b0, 1'b0, 5'd7, 32'h12345678, 1'b1})
            $display("FAIL abort_post_write: got %b/%b/%h/%h/%b exp 0/0/07/12345678/1", csb_n3, we_n3, addr3, sram_data_in3, a_ack3);
        else passed++;
        a_req = 1'b0;
        step();
        total++;
        if ({busy3, a_ack3} !== 2'b00)
            $display("FAIL abort_post_idle: got %b exp 00", {busy3, a_ack3});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int acks = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            a_req = 1'b1; a_we_n = 1'b0; a_addr = 5'(10 + i); a_wdata = 32'h1000 + i;
            step();
            if (!csb_n1 && !we_n1) strobes++;
            if (a_ack1) acks++;
            total++;
            if ({a_ack1, csb_n1, we_n1, addr1} !== {3'b100, 5'(10 + i)})
                $display("FAIL b2b_access%0d: got %b addr %h exp 100 addr %h", i, {a_ack1, csb_n1, we_n1}, addr1, 5'(10 + i));
            else passed++;
            a_req = 1'b0;
            step();
            if (!csb_n1 && !we_n1) strobes++;
            if (a_ack1) acks++;
            total++;
            if ({a_ack1, csb_n1, busy1} !== 3'b010)
                $display("FAIL b2b_idle%0d: got %b exp 010", i, {a_ack1, csb_n1, busy1});
            else passed++;
        end
        step();
        if (!csb_n1 && !we_n1) strobes++;
        if (a_ack1) acks++;
        total++;
        if (strobes != 3 || acks != 3)
            $display("FAIL b2b_counts: got strobes %0d acks %0d exp 3 3", strobes, acks);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem1[10 + i] !== 32'h1000 + i)
                $display("FAIL b2b_mem%0d: got %h exp %h", i, mem1[10 + i], 32'h1000 + i);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_fixed_prio();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: RD_LAT, default 1, SRAM read latency in cycles after the access cycle; legal range 1..4.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_fixed_prio  in  1  1 = port A always wins; 0 = round-robin.
- a_req  in  1  port A request; level, held until a_ack.
- a_we_n  in  1  port A: 0 = write, 1 = read.
- a_addr  in  5  port A word address.
- a_wdata  in  32  port A write data.
- a_ack  out  1  port A completion pulse.
- a_rdata  out  32  port A read data.
- b_req, b_we_n, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B.
- csb_n  out  1  SRAM chip select, active-low.
- we_n  out  1  SRAM write enable, active-low.
- addr  out  5  SRAM address.
- sram_data_in  out  32  SRAM write data.
- sram_data_out  in  32  SRAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, WAIT and RESP.
REQ-004 IDLE: when a_req or b_req is high, SHALL select a winner, latch its we_n, addr and wdata, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-005 Arbitration with cfg_fixed_prio=1: A wins when both request.
REQ-006 Arbitration with cfg_fixed_prio=0: when both request, the port not granted last wins; a sole requester always wins.
REQ-007 last_grant SHALL update on every grant; cfg_fixed_prio is sampled only in IDLE.
REQ-008 ACCESS (exactly 1 cycle): outputs SHALL be csb_n=0, we_n=latched we_n, addr=latched addr, sram_data_in=latched wdata (0 on a read).
REQ-009 In every state other than ACCESS: csb_n=1, we_n=1, addr=0, sram_data_in=0.
REQ-010 Write: winner's ack SHALL be high during the ACCESS cycle; next state IDLE.
REQ-011 Read: ACCESS -> WAIT for exactly RD_LAT cycles, tracked by a down-counter.
REQ-012 Read: on the edge ending the last WAIT cycle, sram_data_out SHALL load into the winner's rdata register; next state RESP.
REQ-013 RESP (1 cycle): winner's ack=1 with rdata already valid; next state IDLE.
REQ-014 The losing port's ack and rdata SHALL be untouched; rdata holds until that port's next read completes.
REQ-015 Latency, req sampled at edge N: write ack in cycle N+1; read ack in cycle N+2+RD_LAT.
REQ-016 ack SHALL be a single-cycle pulse; at most one of a_ack/b_ack is high in any cycle.
REQ-017 A requester drops req on the edge ending its ack cycle; the FSM is then in IDLE and SHALL NOT re-grant that request.
REQ-018 If req deasserts before ack (protocol violation), the latched transaction SHALL complete and still pulse ack.
REQ-019 Request inputs are ignored outside IDLE; no queueing beyond the held req level.
REQ-020 busy SHALL be 1 in ACCESS, WAIT and RESP; 0 in IDLE.

Reset
REQ-021 While rst=1 at a clock edge: state=IDLE, last_grant=B (A wins the first contention), counter=0, csb_n=1, we_n=1, addr=0, sram_data_in=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0.
REQ-022 Reset mid-transaction SHALL abort it: no ack and no rdata update afterwards, and csb_n=1 in the cycle after the reset edge.

Verification
REQ-023 A write, addr=5'h03, wdata=32'hDEADBEEF -> next cycle csb_n=0, we_n=0, addr=3, sram_data_in=DEADBEEF, a_ack=1; the cycle after, busy=0.
REQ-024 RD_LAT=1, B read addr=5'h03, SRAM model returns DEADBEEF -> b_ack high 3 cycles after req sampled, b_rdata=DEADBEEF; a_rdata unchanged.
REQ-025 Round-robin, a_req and b_req both held high for 4 transactions from reset -> grant order A,B,A,B.
REQ-026 cfg_fixed_prio=1, both held high -> A granted every time, B never acked; releasing a_req -> B granted next IDLE.
REQ-027 RD_LAT=3 read with rst pulsed during WAIT -> no ack, rdata stays 0, csb_n=1, state IDLE; a subsequent write completes normally.
REQ-028 Back-to-back A writes with a_req re-raised the cycle after ack -> exactly one ack per transaction, no duplicated SRAM write.
